// File: rtl/z_scan_pkg.sv
// Shared types and helpers for the Z-order scan block sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package z_scan_pkg;

    // Pixels per 8x8 block; the generator holds zid_vld for this many cycles per sob.
    localparam int ZS_BLK_PIX = 64;

    typedef enum logic [1:0] {
        ZS_IDLE     = 2'd0,
        ZS_WAIT_RDY = 2'd1,
        ZS_RUN      = 2'd2,
        ZS_GAP      = 2'd3
    } zs_state_t;

    // clog2 with a floor of 1 bit, so single-entry dimensions still get a real port.
    function automatic int zs_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zs_tmr.sv
// Loadable saturating down-counter with a zero flag (gap and watchdog timing).
// Latency: load/decrement take effect the cycle after ld/dec; zero is combinational from the count.
// Backpressure: none; dec at zero holds zero.
// Ports: clk, rst_n, ld (load ld_val, wins over dec), ld_val, dec, zero.
module zs_tmr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/z_scan_sched.sv
// Block-level sequencer: raster walk over BLK_W x BLK_H blocks, one sob per block, with gap and watchdog.
// Latency: all outputs registered; sob one cycle after blk_rdy seen in WAIT_RDY, blk_done one cycle after zid_vld falls.
// Backpressure: blk_rdy low holds WAIT_RDY indefinitely; abort (sync) returns to IDLE from any state.
// Ports: frame_start/abort/blk_rdy/zid_vld in; sob, blk_x, blk_y, busy, blk_done, frame_done, err out.
module z_scan_sched
    import z_scan_pkg::*;
#(
    parameter int BLK_W = 8,
    parameter int BLK_H = 4,
    parameter int GAP   = 2,
    parameter int TO    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       abort,
    input  logic                       blk_rdy,
    input  logic                       zid_vld,
    output logic                       sob,
    output logic [zs_width(BLK_W)-1:0] blk_x,
    output logic [zs_width(BLK_H)-1:0] blk_y,
    output logic                       busy,
    output logic                       blk_done,
    output logic                       frame_done,
    output logic                       err
);

    localparam int XW = zs_width(BLK_W);
    localparam int YW = zs_width(BLK_H);
    localparam int TW = zs_width(((GAP > TO) ? GAP : TO) + 1);

    localparam logic [XW-1:0] X_LAST = XW'(BLK_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(BLK_H - 1);

    // Both timers count the cycle they are loaded in, hence the -1 on the load value.
    localparam int            GAP_LDI = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_LDI);
    localparam logic [TW-1:0] WD_LD   = TW'(TO - 1);

    zs_state_t       state, state_nxt;
    logic            vld_seen, vld_seen_nxt;
    logic            sob_nxt, busy_nxt, blk_done_nxt, frame_done_nxt, err_nxt;
    logic [XW-1:0]   bx_nxt;
    logic [YW-1:0]   by_nxt;
    logic            gap_ld, gap_dec, gap_zero;
    logic            wd_ld, wd_dec, wd_zero;

    zs_tmr #(.W(TW)) u_gap_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (gap_ld),
        .ld_val (GAP_LD),
        .dec    (gap_dec),
        .zero   (gap_zero)
    );

    zs_tmr #(.W(TW)) u_wd_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (wd_ld),
        .ld_val (WD_LD),
        .dec    (wd_dec),
        .zero   (wd_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ZS_IDLE;
            vld_seen   <= 1'b0;
            sob        <= 1'b0;
            busy       <= 1'b0;
            blk_done   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            blk_x      <= '0;
            blk_y      <= '0;
        end else begin
            state      <= state_nxt;
            vld_seen   <= vld_seen_nxt;
            sob        <= sob_nxt;
            busy       <= busy_nxt;
            blk_done   <= blk_done_nxt;
            frame_done <= frame_done_nxt;
            err        <= err_nxt;
            blk_x      <= bx_nxt;
            blk_y      <= by_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        vld_seen_nxt   = vld_seen;
        sob_nxt        = 1'b0;
        busy_nxt       = busy;
        blk_done_nxt   = 1'b0;
        frame_done_nxt = 1'b0;
        err_nxt        = 1'b0;
        bx_nxt         = blk_x;
        by_nxt         = blk_y;
        gap_ld         = 1'b0;
        gap_dec        = 1'b0;
        wd_ld          = 1'b0;
        wd_dec         = 1'b0;

        if (abort) begin
            state_nxt    = ZS_IDLE;
            busy_nxt     = 1'b0;
            vld_seen_nxt = 1'b0;
            bx_nxt       = '0;
            by_nxt       = '0;
        end else begin
            case (state)
                ZS_IDLE: begin
                    if (frame_start) begin
                        state_nxt = ZS_WAIT_RDY;
                        busy_nxt  = 1'b1;
                        bx_nxt    = '0;
                        by_nxt    = '0;
                    end
                end

                ZS_WAIT_RDY: begin
                    // The watchdog starts with the sob cycle, which is the first RUN cycle.
                    if (blk_rdy) begin
                        state_nxt    = ZS_RUN;
                        sob_nxt      = 1'b1;
                        vld_seen_nxt = 1'b0;
                        wd_ld        = 1'b1;
                    end
                end

                ZS_RUN: begin
                    if (zid_vld) begin
                        vld_seen_nxt = 1'b1;
                    end else if (vld_seen) begin
                        // Falling edge of the valid window: block complete.
                        blk_done_nxt = 1'b1;
                        vld_seen_nxt = 1'b0;
                        if ((blk_x == X_LAST) && (blk_y == Y_LAST)) begin
                            frame_done_nxt = 1'b1;
                            busy_nxt       = 1'b0;
                            state_nxt      = ZS_IDLE;
                            bx_nxt         = '0;
                            by_nxt         = '0;
                        end else begin
                            if (blk_x == X_LAST) begin
                                bx_nxt = '0;
                                by_nxt = blk_y + YW'(1);
                            end else begin
                                bx_nxt = blk_x + XW'(1);
                            end
                            if (GAP == 0) begin
                                state_nxt = ZS_WAIT_RDY;
                            end else begin
                                state_nxt = ZS_GAP;
                                gap_ld    = 1'b1;
                            end
                        end
                    end else if (wd_zero) begin
                        // Generator never raised zid_vld within TO cycles.
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ZS_IDLE;
                        bx_nxt    = '0;
                        by_nxt    = '0;
                    end else begin
                        wd_dec = 1'b1;
                    end
                end

                ZS_GAP: begin
                    if (gap_zero) begin
                        state_nxt = ZS_WAIT_RDY;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end

                default: state_nxt = ZS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_scan_sched.sv
`timescale 1ns/1ps
module tb_z_scan_sched;
    import z_scan_pkg::*;

    localparam int XW = zs_width(2);
    localparam int YW = zs_width(2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic abort = 1'b0;
    logic blk_rdy = 1'b1;
    logic gen_en = 1'b1;

    logic zid_vld_a, sob_a, busy_a, blk_done_a, frame_done_a, err_a;
    logic [XW-1:0] bx_a;
    logic [YW-1:0] by_a;
    logic zid_vld_b, sob_b, busy_b, blk_done_b, frame_done_b, err_b;
    logic [XW-1:0] bx_b;
    logic [YW-1:0] by_b;

    always #5 clk = ~clk;

    z_scan_sched #(.BLK_W(2), .BLK_H(2), .GAP(2), .TO(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .blk_rdy(blk_rdy), .zid_vld(zid_vld_a), .sob(sob_a), .blk_x(bx_a), .blk_y(by_a),
        .busy(busy_a), .blk_done(blk_done_a), .frame_done(frame_done_a), .err(err_a)
    );

    z_scan_sched #(.BLK_W(2), .BLK_H(2), .GAP(0), .TO(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .blk_rdy(blk_rdy), .zid_vld(zid_vld_b), .sob(sob_b), .blk_x(bx_b), .blk_y(by_b),
        .busy(busy_b), .blk_done(blk_done_b), .frame_done(frame_done_b), .err(err_b)
    );

    // Scan generator model: 64-cycle valid window starting the cycle after sob.
    int gcnt_a = 0;
    int gcnt_b = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_a <= 0;
            gcnt_b <= 0;
        end else begin
            if (abort)            gcnt_a <= 0;
            else if (sob_a)       gcnt_a <= ZS_BLK_PIX;
            else if (gcnt_a > 0)  gcnt_a <= gcnt_a - 1;
            if (abort)            gcnt_b <= 0;
            else if (sob_b)       gcnt_b <= ZS_BLK_PIX;
            else if (gcnt_b > 0)  gcnt_b <= gcnt_b - 1;
        end
    end
    assign zid_vld_a = gen_en && (gcnt_a > 0);
    assign zid_vld_b = gen_en && (gcnt_b > 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-test schedule and observations (cycle numbers relative to t0).
    int t0, fs0, fs1, ab_at, rst_at, snap_at, lo_from, lo_to;
    bit rdy_mode;
    int sob_qa[$], pos_qa[$], done_qa[$], fdone_qa[$], err_qa[$];
    int sob_qb[$], done_qb[$];
    int busy_fall_a, bad_sob, snap_busy, rst_vec;
    logic prev_busy_a, prev_rdy;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int e[$]);
        chk({tag, ".len"}, q.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : -1, e[i]);
    endtask

    task automatic begin_test(input int f0, input int f1, input int ab, input int rs,
                              input int snap, input bit rmode);
        fs0 = f0; fs1 = f1; ab_at = ab; rst_at = rs; snap_at = snap; rdy_mode = rmode;
        lo_from = -1; lo_to = -1;
        sob_qa.delete(); pos_qa.delete(); done_qa.delete(); fdone_qa.delete(); err_qa.delete();
        sob_qb.delete(); done_qb.delete();
        busy_fall_a = -1; bad_sob = 0; snap_busy = -1; rst_vec = -1;
        prev_busy_a = 1'b0; prev_rdy = 1'b1;
        t0 = cyc + 1;
    endtask

    // One clock cycle: drive inputs at the falling edge, sample outputs just after.
    task automatic step();
        int rel;
        @(negedge clk);
        rel = cyc - t0;
        frame_start = (rel == fs0) || (rel == fs1);
        abort = (rel == ab_at);
        if (rel == rst_at) rst_n = 1'b0;
        else if (rel == rst_at + 1) rst_n = 1'b1;
        blk_rdy = !(rdy_mode && (rel >= lo_from) && (rel <= lo_to));
        #1;
        if (sob_a) begin
            sob_qa.push_back(rel);
            pos_qa.push_back(int'({bx_a, by_a}));
            if (!prev_rdy || zid_vld_a) bad_sob++;
        end
        if (sob_b) begin
            sob_qb.push_back(rel);
            if (!prev_rdy || zid_vld_b) bad_sob++;
        end
        if (blk_done_a) done_qa.push_back(rel);
        if (blk_done_b) done_qb.push_back(rel);
        if (frame_done_a) fdone_qa.push_back(rel);
        if (err_a) err_qa.push_back(rel);
        if (blk_done_a && rdy_mode) begin
            lo_from = rel + 2;
            lo_to   = rel + 11;
        end
        if (prev_busy_a && !busy_a && busy_fall_a < 0) busy_fall_a = rel;
        if (rel == snap_at) snap_busy = int'(busy_a);
        if (rel == rst_at)
            rst_vec = int'({sob_a, busy_a, blk_done_a, frame_done_a, err_a, bx_a, by_a});
        prev_busy_a = busy_a;
        prev_rdy = blk_rdy;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_start = 1'b0; abort = 1'b0; blk_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int e[$];
        int e2[$];

        repeat (3) @(negedge clk);
        #1;
        chk("rst_sob", int'(sob_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_blk_done", int'(blk_done_a), 0);
        chk("rst_frame_done", int'(frame_done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_pos", int'({bx_a, by_a}), 0);
        rst_n = 1'b1;

        // Full 2x2 frame, blk_rdy tied high; dut_b has GAP=0.
        begin_test(0, -1, -1, -100, -1, 1'b0);
        repeat (300) step();
        e = '{2, 71, 140, 209};     chk_q("t1_sob", sob_qa, e);
        e = '{68, 137, 206, 275};   chk_q("t1_done", done_qa, e);
        e = '{275};                 chk_q("t1_fdone", fdone_qa, e);
        e = '{0, 2, 1, 3};          chk_q("t1_pos", pos_qa, e);
        chk("t1_busy_fall", busy_fall_a, 275);
        chk("t1_err_cnt", err_qa.size(), 0);
        e = '{2, 69, 136, 203};     chk_q("gap0_sob", sob_qb, e);
        e = '{68, 135, 202, 269};   chk_q("gap0_done", done_qb, e);
        chk("t1_sob_guard", bad_sob, 0);
        hard_reset();

        // blk_rdy low for 10 cycles after each gap.
        begin_test(0, -1, -1, -100, -1, 1'b1);
        repeat (320) step();
        e = '{2, 81, 160, 239};     chk_q("t2_sob", sob_qa, e);
        e = '{68, 147, 226, 305};   chk_q("t2_done", done_qa, e);
        e = '{305};                 chk_q("t2_fdone", fdone_qa, e);
        e = '{0, 2, 1, 3};          chk_q("t2_pos", pos_qa, e);
        chk("t2_sob_guard", bad_sob, 0);
        hard_reset();

        // Generator disconnected: watchdog fires.
        gen_en = 1'b0;
        begin_test(0, -1, -1, -100, -1, 1'b0);
        repeat (20) step();
        e = '{2};                   chk_q("wd_sob", sob_qa, e);
        e = '{6};                   chk_q("wd_err", err_qa, e);
        chk("wd_busy_fall", busy_fall_a, 6);
        chk("wd_done_cnt", done_qa.size(), 0);
        gen_en = 1'b1;
        hard_reset();

        // Abort mid-block, then restart.
        begin_test(0, 40, 30, -100, 30, 1'b0);
        repeat (60) step();
        chk("ab_busy_at30", snap_busy, 1);
        chk("ab_busy_fall", busy_fall_a, 31);
        chk("ab_done_cnt", done_qa.size(), 0);
        chk("ab_fdone_cnt", fdone_qa.size(), 0);
        e = '{2, 42};               chk_q("ab_sob", sob_qa, e);
        e2 = '{0, 0};               chk_q("ab_pos", pos_qa, e2);
        hard_reset();

        // Ignored frame_start while busy, then reset mid-frame.
        begin_test(0, 20, -1, 100, 99, 1'b0);
        repeat (200) step();
        chk("rs_busy_at99", snap_busy, 1);
        chk("rs_outputs_in_reset", rst_vec, 0);
        e = '{2, 71};               chk_q("rs_sob", sob_qa, e);
        e = '{68};                  chk_q("rs_done", done_qa, e);
        chk("rs_fdone_cnt", fdone_qa.size(), 0);
        chk("rs_err_cnt", err_qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
